sm_ahb_ram_ws: RTL and testbench

SM_AHB_RAM_WS -- requirements
Module: sm_ahb_ram_ws

---
 rtl/sm_ahb_ram_ws.sv | 119 +++++++++++
 tb/tb_sm_ahb_ram_ws.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_ahb_ram_ws.sv
// rtl/sm_ahb_ram_ws.sv - AHB-Lite word RAM slave with fixed data-phase wait states
// Out-of-range transfers get a two-cycle ERROR response and never touch the RAM.
module sm_ahb_ram_ws #(
    parameter int SIZE        = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int AW = $clog2(SIZE);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_LAST = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [2:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [31:0]   hrdata_q;
    logic [31:0]   mem [SIZE];

    logic          addr_ok;
    logic          can_accept;
    logic          accept;
    logic          last_rd;
    logic          last_wr;
    logic [31:0]   rd_word;
    logic          unused_bits;

    assign unused_bits = ^{HADDR[1:0], HTRANS[0]};

    assign addr_ok    = (HADDR[31:AW+2] == '0);
    // A new address phase is only taken while this slave is not stalling the bus.
    assign can_accept = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
    assign accept     = !rst && can_accept && HSEL && HREADY && HTRANS[1];

    assign last_rd = (state_q == S_LAST) && !write_q;
    assign last_wr = (state_q == S_LAST) && write_q;
    // Asynchronous read port: a write committed on the previous edge is already visible.
    assign rd_word = mem[idx_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        case (state_q)
            S_IDLE, S_LAST, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = HADDR[AW+1:2];
                    write_d = HWRITE;
                    if (!addr_ok) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = S_LAST;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_LAST;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            hrdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            if (last_rd) begin
                hrdata_q <= rd_word;
            end
        end
    end

    // RAM contents survive reset; a reset on the LAST edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && last_wr) begin
            mem[idx_q] <= HWDATA;
        end
    end

    assign HRDATA    = last_rd ? rd_word : hrdata_q;
    assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule

// File: tb/tb_sm_ahb_ram_ws.sv
// tb/tb_sm_ahb_ram_ws.sv - randomized bench for sm_ahb_ram_ws at WAIT_STATES 0, 1, 3 and 7
module tb_sm_ahb_ram_ws;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       rst = 4'hF;
    logic [3:0]       hsel = '0, hwrite = '0, hready_ovr = '0;
    logic [3:0]       hready, hreadyout, hresp;
    logic [3:0][31:0] haddr = '0, hwdata = '0, hrdata;
    logic [3:0][1:0]  htrans = '0;

    // Single-slave bus: HREADY follows the slave unless deliberately pulled low.
    assign hready = hreadyout & ~hready_ovr;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sm_ahb_ram_ws #(
            .SIZE(64),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7)
        ) u_dut (
            .clk(clk), .rst(rst[g]), .HSEL(hsel[g]), .HADDR(haddr[g]), .HWRITE(hwrite[g]),
            .HTRANS(htrans[g]), .HWDATA(hwdata[g]), .HREADY(hready[g]),
            .HRDATA(hrdata[g]), .HREADYOUT(hreadyout[g]), .HRESP(hresp[g])
        );
    end

    int unsigned      wsv [4] = '{0, 1, 3, 7};
    logic [31:0]      mmem [4][64];
    logic [31:0]      mheld [4];
    logic [3:0]       exp_rdy = 4'hF, exp_rsp = '0;
    logic [3:0][31:0] exp_rd = '0;
    bit               chk_en = 0;
    int               checks = 0, errors = 0;
    int               lowcnt [4] = '{0, 0, 0, 0};

    // Outstanding data phase: 0 none, 1 okay transfer, 2 first error cycle, 3 second error cycle
    int               dp_kind = 0;
    int               dp_wait = 0;
    bit               dp_wr = 0;
    int               dp_idx = 0;
    logic [31:0]      dp_wd = '0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h want %h", nm, k, $time, act, ex);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                chk("hreadyout", k, 32'(hreadyout[k]), 32'(exp_rdy[k]));
                chk("hresp", k, 32'(hresp[k]), 32'(exp_rsp[k]));
                chk("hrdata", k, hrdata[k], exp_rd[k]);
                if (!hreadyout[k]) lowcnt[k]++;
            end
        end
    end

    // One bus cycle on instance k. The address inputs are presented only when the
    // model says the previous data phase ends this cycle (taken=1).
    task automatic step(input int k, input logic a_sel, input logic [1:0] a_trans, input logic a_wr,
                        input logic [31:0] a_addr, input logic [31:0] a_wd, input logic a_ovr,
                        input logic r, output bit taken);
        bit last = 1;
        bit ok_last = 0;
        rst[k]     = r;
        exp_rdy[k] = 1'b1;
        exp_rsp[k] = 1'b0;
        exp_rd[k]  = mheld[k];
        case (dp_kind)
            1: if (dp_wait > 0) begin
                   exp_rdy[k] = 1'b0;
                   dp_wait--;
                   last = 0;
               end else begin
                   ok_last = 1;
                   if (!dp_wr) exp_rd[k] = mmem[k][dp_idx];
               end
            2: begin exp_rdy[k] = 1'b0; exp_rsp[k] = 1'b1; last = 0; dp_kind = 3; end
            3: exp_rsp[k] = 1'b1;
            default: ;
        endcase
        hwdata[k] = (dp_kind != 0) ? dp_wd : $urandom();
        if (last) begin
            hsel[k] = a_sel; htrans[k] = a_trans; hwrite[k] = a_wr;
            haddr[k] = a_addr; hready_ovr[k] = a_ovr;
        end else begin
            hsel[k] = 1'b1; htrans[k] = 2'b10; hwrite[k] = 1'($urandom());
            haddr[k] = $urandom() & 32'h1FC; hready_ovr[k] = 1'b0;
        end
        taken = last;
        if (r) begin
            mheld[k] = '0;
            dp_kind  = 0;
        end else begin
            if (ok_last) begin
                if (dp_wr) mmem[k][dp_idx] = dp_wd;
                else       mheld[k] = mmem[k][dp_idx];
            end
            if (last) begin
                if (a_sel && a_trans[1] && !a_ovr) begin
                    dp_kind = (a_addr[31:8] == 24'd0) ? 1 : 2;
                    dp_wait = int'(wsv[k]);
                    dp_wr   = a_wr;
                    dp_idx  = int'(a_addr[7:2]);
                    dp_wd   = a_wd;
                end else begin
                    dp_kind = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic a_sel, input logic [1:0] a_trans, input logic a_wr,
                         input logic [31:0] a_addr, input logic [31:0] a_wd, input logic a_ovr,
                         input logic r);
        bit t = 0;
        int n = 0;
        do begin
            step(k, a_sel, a_trans, a_wr, a_addr, a_wd, a_ovr, r, t);
            n++;
        end while (!t && n < 20);
        if (!t) chk("issue_timeout", k, 32'(n), 32'd0);
    endtask

    task automatic issue(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        drive(k, 1'b1, 2'b10, wr, addr, wd, 1'b0, 1'b0);
    endtask

    task automatic idle(input int k, input int n);
        bit t;
        for (int i = 0; i < n; i++) step(k, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, t);
    endtask

    initial begin
        bit t;
        for (int k = 0; k < 4; k++) mheld[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = '0;
        chk_en = 1;
        for (int k = 0; k < 4; k++) begin
            chk("reset_hreadyout", k, 32'(hreadyout[k]), 32'd1);
            chk("reset_hresp", k, 32'(hresp[k]), 32'd0);
            chk("reset_hrdata", k, hrdata[k], 32'd0);
        end

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) issue(k, 1'b1, 32'(i * 4), {16'hC0DE, 16'(i)});
            idle(k, 10);
        end

        lowcnt[1] = 0;
        issue(1, 1'b1, 32'h10, 32'hDEADBEEF);
        idle(1, 3);
        chk("ws1_write_wait_cycles", 1, 32'(lowcnt[1]), 32'd1);
        issue(1, 1'b0, 32'h10, 32'd0);
        idle(1, 3);
        chk("ws1_read_data", 1, hrdata[1], 32'hDEADBEEF);

        lowcnt[0] = 0;
        issue(0, 1'b1, 32'h8, 32'h0000A5A5);
        issue(0, 1'b0, 32'h8, 32'd0);
        idle(0, 2);
        chk("ws0_forward_data", 0, hrdata[0], 32'h0000A5A5);
        chk("ws0_no_stall", 0, 32'(lowcnt[0]), 32'd0);

        lowcnt[1] = 0;
        issue(1, 1'b1, 32'h100, 32'hFFFF0000);
        idle(1, 3);
        chk("err_low_cycles", 1, 32'(lowcnt[1]), 32'd1);
        chk("err_hrdata_kept", 1, hrdata[1], 32'hDEADBEEF);
        issue(1, 1'b0, 32'h0, 32'd0);
        idle(1, 3);
        chk("err_word0_unchanged", 1, hrdata[1], 32'hC0DE0000);

        issue(2, 1'b1, 32'h4, 32'h12345678);
        step(2, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, t);
        step(2, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, t);
        chk("rst_abort_hreadyout", 2, 32'(hreadyout[2]), 32'd1);
        chk("rst_abort_hresp", 2, 32'(hresp[2]), 32'd0);
        chk("rst_abort_hrdata", 2, hrdata[2], 32'd0);
        issue(2, 1'b0, 32'h4, 32'd0);
        idle(2, 5);
        chk("rst_abort_word1", 2, hrdata[2], 32'hC0DE0001);

        lowcnt[3] = 0;
        step(3, 1'b1, 2'b00, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0, t);
        step(3, 1'b1, 2'b10, 1'b1, 32'h20, 32'h22222222, 1'b1, 1'b0, t);
        step(3, 1'b0, 2'b10, 1'b1, 32'h20, 32'h33333333, 1'b0, 1'b0, t);
        step(3, 1'b1, 2'b01, 1'b1, 32'h20, 32'h44444444, 1'b0, 1'b0, t);
        idle(3, 1);
        chk("no_start_stalls", 3, 32'(lowcnt[3]), 32'd0);
        lowcnt[3] = 0;
        issue(3, 1'b0, 32'h20, 32'd0);
        idle(3, 10);
        chk("ws7_low_cycles", 3, 32'(lowcnt[3]), 32'd7);
        chk("no_start_word8", 3, hrdata[3], 32'hC0DE0008);

        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 150; n++) begin
                logic        sel, wr, ovr, r;
                logic [1:0]  tr;
                logic [31:0] addr;
                sel  = ($urandom_range(0, 7) != 0);
                tr   = ($urandom_range(0, 3) != 0) ? {1'b1, 1'($urandom())} : {1'b0, 1'($urandom())};
                wr   = 1'($urandom());
                ovr  = ($urandom_range(0, 9) == 0);
                r    = ($urandom_range(0, 49) == 0);
                addr = ($urandom_range(0, 9) != 0) ? 32'($urandom_range(0, 255)) : ($urandom() | 32'h100);
                drive(k, sel, tr, wr, addr, $urandom(), ovr, r);
            end
            idle(k, 10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
